// File: rtl/kyber_pkg.sv
// Shared Kyber constants and Montgomery pipeline sizing.
// MONT_CANONICAL_EN adds a fourth stage and widens the in-flight count.
package kyber_pkg;

    localparam int KYBER_Q      = 3329;
    localparam int KYBER_QINV   = -3327;
    localparam int KYBER_COEF_W = 16;

    typedef logic signed [KYBER_COEF_W-1:0]   coef_t;
    typedef logic signed [2*KYBER_COEF_W-1:0] acc_t;

`ifdef MONT_CANONICAL_EN
    localparam int MONT_STAGES = 4;
`else
    localparam int MONT_STAGES = 3;
`endif

    localparam int MONT_CNT_W = $clog2(MONT_STAGES + 1);

endpackage

// File: rtl/mont_lane.sv
// Combinational per-stage arithmetic for one Montgomery lane.
// MONT_CANONICAL_EN adds the conditional +Q correction used by stage S4.
module mont_lane
    import kyber_pkg::*;
#(
    parameter int COEF_W = KYBER_COEF_W,
    parameter int Q      = KYBER_Q,
    parameter int QINV   = KYBER_QINV
) (
    input  logic signed [COEF_W-1:0]   a_lo,
    output logic signed [COEF_W-1:0]   m_nxt,
    input  logic signed [COEF_W-1:0]   m_s1,
    output logic signed [2*COEF_W-1:0] p_nxt,
    input  logic signed [2*COEF_W-1:0] a_s2,
    input  logic signed [2*COEF_W-1:0] p_s2,
    output logic signed [COEF_W-1:0]   t_nxt
`ifdef MONT_CANONICAL_EN
    ,
    input  logic signed [COEF_W-1:0]   t_s3,
    output logic signed [COEF_W-1:0]   tc_nxt
`endif
);

    localparam logic signed [COEF_W-1:0]   QINV_N = COEF_W'(QINV);
    localparam logic signed [2*COEF_W-1:0] Q_W    = (2*COEF_W)'(Q);

    logic signed [2*COEF_W-1:0] m_ext;

    // Only the low COEF_W bits of the product matter, so multiply at COEF_W.
    assign m_nxt = a_lo * QINV_N;

    assign m_ext = {{COEF_W{m_s1[COEF_W-1]}}, m_s1};
    assign p_nxt = m_ext * Q_W;

    assign t_nxt = COEF_W'((a_s2 - p_s2) >>> COEF_W);

`ifdef MONT_CANONICAL_EN
    localparam logic signed [COEF_W-1:0] Q_N = COEF_W'(Q);

    assign tc_nxt = t_s3[COEF_W-1] ? (t_s3 + Q_N) : t_s3;
`endif

endmodule

// File: rtl/montgomery_reduce_pipe.sv
// Stallable multi-lane Montgomery reducer: t = a * 2^-COEF_W mod Q, one beat per cycle.
// MONT_CANONICAL_EN appends a correction stage so outputs land in 0..Q-1 (latency 4).
module montgomery_reduce_pipe
    import kyber_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int COEF_W = KYBER_COEF_W,
    parameter int Q      = KYBER_Q,
    parameter int QINV   = KYBER_QINV,
    parameter int TAG_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*2*COEF_W-1:0] in_a,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*COEF_W-1:0]   out_t,
    output logic [TAG_W-1:0]          out_tag,
    output logic [MONT_CNT_W-1:0]     inflight
);

    localparam int ST = MONT_STAGES;

    logic stall;
    logic accept;
    logic xfer;

    logic [ST-1:0]    vld;
    logic [TAG_W-1:0] tag_q [ST];

    logic signed [2*COEF_W-1:0] a1    [LANES];
    logic signed [COEF_W-1:0]   m1    [LANES];
    logic signed [2*COEF_W-1:0] a2    [LANES];
    logic signed [2*COEF_W-1:0] p2    [LANES];
    logic signed [COEF_W-1:0]   m_nxt [LANES];
    logic signed [2*COEF_W-1:0] p_nxt [LANES];
    logic signed [COEF_W-1:0]   t_nxt [LANES];
    logic signed [COEF_W-1:0]   t_out [LANES];
`ifdef MONT_CANONICAL_EN
    logic signed [COEF_W-1:0]   t3     [LANES];
    logic signed [COEF_W-1:0]   tc_nxt [LANES];
`endif

    assign out_valid = vld[ST-1];
    assign out_tag   = tag_q[ST-1];
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mont_lane #(
            .COEF_W (COEF_W),
            .Q      (Q),
            .QINV   (QINV)
        ) u_lane (
            .a_lo   (in_a[l*2*COEF_W +: COEF_W]),
            .m_nxt  (m_nxt[l]),
            .m_s1   (m1[l]),
            .p_nxt  (p_nxt[l]),
            .a_s2   (a2[l]),
            .p_s2   (p2[l]),
            .t_nxt  (t_nxt[l])
`ifdef MONT_CANONICAL_EN
            ,
            .t_s3   (t3[l]),
            .tc_nxt (tc_nxt[l])
`endif
        );

        assign out_t[l*COEF_W +: COEF_W] = t_out[l];
    end

    // Internal datapath registers carry no reset; only valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int l = 0; l < LANES; l++) begin
                a1[l] <= in_a[l*2*COEF_W +: 2*COEF_W];
                m1[l] <= m_nxt[l];
                a2[l] <= a1[l];
                p2[l] <= p_nxt[l];
`ifdef MONT_CANONICAL_EN
                t3[l] <= t_nxt[l];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            for (int s = 0; s < ST; s++) begin
                tag_q[s] <= '0;
            end
            for (int l = 0; l < LANES; l++) begin
                t_out[l] <= '0;
            end
        end else if (!stall) begin
            vld      <= {vld[ST-2:0], accept};
            tag_q[0] <= in_tag;
            for (int s = 1; s < ST; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            for (int l = 0; l < LANES; l++) begin
`ifdef MONT_CANONICAL_EN
                t_out[l] <= tc_nxt[l];
`else
                t_out[l] <= t_nxt[l];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            case ({accept, xfer})
                2'b10:   inflight <= inflight + MONT_CNT_W'(1);
                2'b01:   inflight <= inflight - MONT_CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_reduce_pipe.sv
// Randomised bench for montgomery_reduce_pipe (4 lanes) against an arithmetic reference model.
// Honours MONT_CANONICAL_EN for latency and output range.
module tb_montgomery_reduce_pipe;

    localparam int LANES = 4;
    localparam int CW    = 16;
    localparam int TAG_W = 8;
`ifdef MONT_CANONICAL_EN
    localparam int LAT = 4;
    localparam logic [15:0] NEG169 = 16'h0C58;
`else
    localparam int LAT = 3;
    localparam logic [15:0] NEG169 = 16'hFF57;
`endif
    localparam int IFW  = $clog2(LAT + 1);
    localparam int AMAX = 3329 * 32768 - 1;
    localparam int AMIN = -3329 * 32768;

    logic                      clk;
    logic                      reset;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*2*CW-1:0]     in_a;
    logic [TAG_W-1:0]          in_tag;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*CW-1:0]       out_t;
    logic [TAG_W-1:0]          out_tag;
    logic [IFW-1:0]            inflight;

    montgomery_reduce_pipe #(
        .LANES  (LANES),
        .COEF_W (CW),
        .Q      (3329),
        .QINV   (-3327),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_t     (out_t),
        .out_tag   (out_tag),
        .inflight  (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference: m = (a mod R) * Q^-1 mod R (signed), t = (a - m*Q) / R exactly.
    function automatic logic [15:0] ref_t(input int a);
        longint lo, m, t;
        lo = longint'(a) & 64'hFFFF;
        m  = (lo * (65536 - 3327)) % 65536;
        if (m >= 32768) m = m - 65536;
        t = (longint'(a) - m * 3329) / 65536;
`ifdef MONT_CANONICAL_EN
        if (t < 0) t = t + 3329;
`endif
        return t[15:0];
    endfunction

    function automatic logic [63:0] ref_vec(input logic [127:0] av);
        logic [63:0] r;
        for (int l = 0; l < LANES; l++) r[l*16 +: 16] = ref_t($signed(av[l*32 +: 32]));
        return r;
    endfunction

    function automatic logic [127:0] pack4(input int a3, input int a2, input int a1, input int a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] rand_vec();
        logic [127:0] r;
        for (int l = 0; l < LANES; l++) begin
            int v;
            v = int'($urandom_range(0, 218169343)) - 109084672;
            r[l*32 +: 32] = v;
        end
        return r;
    endfunction

    typedef struct {
        logic [63:0] t;
        logic [7:0]  tag;
        int          acc;
        int          st;
    } exp_t;

    exp_t sbq[$];
    int   edge_n    = 0;
    int   stall_cnt = 0;

    // Scoreboard: evaluated mid-cycle for the upcoming rising edge.
    initial begin
        exp_t        e;
        bit          prev_stall;
        logic [63:0] prev_t;
        logic [7:0]  prev_tag;
        bit          exp_rdy;
        prev_stall = 1'b0;
        prev_t     = '0;
        prev_tag   = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sbq.delete();
                prev_stall = 1'b0;
            end else begin
                exp_rdy = !(out_valid && !out_ready);
                chk("in_ready", in_ready, exp_rdy);
                chk("inflight", inflight, sbq.size());
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_t", out_t, prev_t);
                    chk("stall_tag", out_tag, prev_tag);
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("out_t", out_t, e.t);
                        chk("out_tag", out_tag, e.tag);
                        chk("latency", edge_n - e.acc, LAT + stall_cnt - e.st);
                    end
                end
                if (in_valid && in_ready) begin
                    e.t   = ref_vec(in_a);
                    e.tag = in_tag;
                    e.acc = edge_n;
                    e.st  = stall_cnt;
                    sbq.push_back(e);
                end
                prev_stall = out_valid && !out_ready;
                prev_t     = out_t;
                prev_tag   = out_tag;
                if (prev_stall) stall_cnt++;
            end
            edge_n++;
        end
    end

    bit bp_mode = 1'b0;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic drive_beat(input logic [127:0] av, input logic [7:0] tg);
        int n;
        bit ok;
        in_valid = 1'b1;
        in_a     = av;
        in_tag   = tg;
        n        = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) begin
                @(posedge clk);
                #1;
            end
            n++;
        end while (!ok && n < 200);
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [7:0] tag_ctr = 8'h00;

    task automatic directed(input string nm, input logic [127:0] av, input logic [63:0] exp);
        int k;
        drive_beat(av, tag_ctr);
        tag_ctr = tag_ctr + 8'd1;
        k = 1;
        while (k < 20) begin
            @(negedge clk);
            if (out_valid) break;
            k++;
        end
        chk({nm, "_lat"}, k, LAT);
        chk({nm, "_t"}, out_t, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (inflight != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", inflight, 0);
    endtask

    initial begin
        longint t0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_tag   = '0;

        chk("pin_65536", ref_t(65536), 64'h1);
        chk("pin_1", ref_t(1), 64'h00A9);
        chk("pin_m1", ref_t(-1), NEG169);
        chk("pin_3329", ref_t(3329), 64'h0);
        chk("pin_min", ref_t(AMIN), 64'h0);
        chk("pin_max", ref_t(AMAX), 64'h0C58);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_out_t", out_t, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;

        directed("d_65536", pack4(0, 0, 0, 65536), 64'h0000_0000_0000_0001);
        directed("d_1", pack4(0, 0, 0, 1), 64'h0000_0000_0000_00A9);
        directed("d_m1", pack4(0, 0, 0, -1), {48'h0, NEG169});
        directed("d_3329", pack4(0, 0, 0, 3329), 64'h0);
        directed("d_min1", pack4(0, 0, 0, AMIN), 64'h0);
        directed("d_lanes", pack4(3329, -1, 1, 65536), {16'h0000, NEG169, 16'h00A9, 16'h0001});
        directed("d_min", pack4(AMIN, AMIN, AMIN, AMIN), 64'h0);
        directed("d_max", pack4(AMAX, AMAX, AMAX, AMAX), 64'h0C58_0C58_0C58_0C58);

        t0 = $time;
        for (int i = 0; i < 1000; i++) begin
            drive_beat(rand_vec(), tag_ctr);
            tag_ctr = tag_ctr + 8'd1;
        end
        chk("throughput_cycles", ($time - t0) / 10, 1000);
        drain();

        bp_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            case (i % 8)
                0:       drive_beat(pack4(AMAX, AMIN, AMAX, AMIN), tag_ctr);
                1:       drive_beat(pack4(AMIN, AMAX, -1, 1), tag_ctr);
                default: drive_beat(rand_vec(), tag_ctr);
            endcase
            tag_ctr = tag_ctr + 8'd1;
        end
        bp_mode = 1'b0;
        @(posedge clk);
        #1;
        drain();

        for (int i = 0; i < 3; i++) begin
            drive_beat(rand_vec(), tag_ctr);
            tag_ctr = tag_ctr + 8'd1;
        end
        #2;
        chk("rst_mid_inflight_pre", inflight, 3);
        reset = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_inflight", inflight, 0);
        chk("rst_mid_out_t", out_t, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        drive_beat(pack4(1, -1, 3329, 65536), 8'hA5);
        repeat (8) @(posedge clk);
        #1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
